// File: rtl/config_lut_chain_pkg.sv
// ---------------------------------------------------------------------------
// config_lut_chain_pkg
// Shared declarations for the serially configured LUT chain.
//   state_e    : controller state (IDLE, LOAD, ACTIVE)
//   calc_total : number of configuration bits held for a given K / NUM_LUTS
// ---------------------------------------------------------------------------
package config_lut_chain_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  // Every LUT stores one bit per address, i.e. 2^K bits each.
  function automatic int calc_total(input int k, input int num_luts);
    return num_luts * (1 << k);
  endfunction

endpackage

// File: rtl/config_lut_chain_lut_cell.sv
// ---------------------------------------------------------------------------
// lut_cell
// One K-input look-up table: returns the table entry addressed by addr.
// Ports:
//   lut_table [2^K] : truth table, entry n is the output for addr == n
//   addr      [K]   : LUT inputs
//   out       [1]   : selected truth table entry
// The truth table port is called lut_table because "table" is a reserved
// word in SystemVerilog.
// ---------------------------------------------------------------------------
module lut_cell #(
  parameter int K = 4
) (
  input  logic [(1<<K)-1:0] lut_table,
  input  logic [K-1:0]      addr,
  output logic              out
);

  assign out = lut_table[addr];

endmodule

// File: rtl/config_lut_chain.sv
// ---------------------------------------------------------------------------
// config_lut_chain
// NUM_LUTS independent K-input LUTs whose truth tables are held in a single
// serial shift chain of TOTAL = NUM_LUTS*2^K bits. A load is started with
// cfg_start, then TOTAL bits are shifted in MSB first (cfg_valid qualifies
// each bit). The bit falling off the top of the chain appears registered on
// cfg_out so several blocks can be daisy-chained. Once TOTAL bits have been
// accepted the LUTs become active and cfg_done is raised.
//
// Ports:
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high
//   cfg_start  : one-cycle request to begin a (re)configuration load
//   cfg_valid  : cfg_data is valid this cycle
//   cfg_data   : serial configuration bit, MSB of the bitstream first
//   cfg_ready  : a bit is accepted this cycle (high throughout LOAD)
//   cfg_out    : registered bit shifted out of chain position TOTAL-1
//   cfg_done   : configuration complete, LUTs active
//   select     : LUT i address in bits [i*K +: K]
//   lut_out    : LUT results, bit i from LUT i (0 unless ACTIVE)
//
// Parameters:
//   K        : inputs per LUT (1..6)
//   NUM_LUTS : number of LUTs (1..16)
//   REG_OUT  : 0 = combinational lut_out, 1 = one clock of output latency
// ---------------------------------------------------------------------------
module config_lut_chain
  import config_lut_chain_pkg::*;
#(
  parameter int K        = 4,
  parameter int NUM_LUTS = 2,
  parameter int REG_OUT  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic                  cfg_data,
  output logic                  cfg_ready,
  output logic                  cfg_out,
  output logic                  cfg_done,
  input  logic [NUM_LUTS*K-1:0] select,
  output logic [NUM_LUTS-1:0]   lut_out
);

  localparam int TOTAL   = calc_total(K, NUM_LUTS);
  localparam int ENTRIES = 1 << K;
  localparam int CW      = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [TOTAL-1:0]      chain_q, chain_d;
  logic                  cfg_out_q, cfg_out_d;
  logic                  shift_en;
  logic [NUM_LUTS-1:0]   lut_raw;
  logic [NUM_LUTS-1:0]   lut_sel;

  // A bit is only ever consumed while loading; cfg_valid elsewhere is ignored.
  assign shift_en = (state_q == LOAD) && cfg_valid;

  // State and datapath registers. Reset wins over every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      chain_q   <= '0;
      cfg_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      chain_q   <= chain_d;
      cfg_out_q <= cfg_out_d;
    end
  end

  // Next-state logic. cfg_start is deliberately not looked at in LOAD, so a
  // stray start pulse cannot restart a load in progress. The move to ACTIVE
  // happens on the same edge that shifts in the last bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_start) state_d = LOAD;
      LOAD:    if (shift_en && (count_q == LAST_IDX)) state_d = ACTIVE;
      ACTIVE:  if (cfg_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Shift chain and bit counter. The counter restarts on every entry into
  // LOAD; the chain contents are kept so the old tables stream out of
  // cfg_out during a reload. The counter stops at TOTAL because no further
  // shifts are possible once ACTIVE is reached.
  always_comb begin
    count_d   = count_q;
    chain_d   = chain_q;
    cfg_out_d = cfg_out_q;
    if ((state_q != LOAD) && (state_d == LOAD)) begin
      count_d = '0;
    end else if (shift_en) begin
      chain_d   = {chain_q[TOTAL-2:0], cfg_data};
      cfg_out_d = chain_q[TOTAL-1];
      count_d   = count_q + 1'b1;
    end
  end

  // LUT i reads its truth table from chain bits [i*2^K +: 2^K], so the first
  // bit of the stream ends up as the top entry of the last LUT.
  for (genvar g = 0; g < NUM_LUTS; g++) begin : g_lut
    lut_cell #(
      .K(K)
    ) u_lut_cell (
      .lut_table(chain_q[g*ENTRIES +: ENTRIES]),
      .addr     (select[g*K +: K]),
      .out      (lut_raw[g])
    );
  end

  // Optional output register. It captures zero outside ACTIVE so that the
  // first ACTIVE cycle never shows a result computed from a partial chain.
  if (REG_OUT != 0) begin : g_reg_out
    logic [NUM_LUTS-1:0] lut_q, lut_d;

    always_comb begin
      lut_d = (state_q == ACTIVE) ? lut_raw : '0;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        lut_q <= '0;
      end else begin
        lut_q <= lut_d;
      end
    end

    assign lut_sel = lut_q;
  end else begin : g_comb_out
    assign lut_sel = lut_raw;
  end

  // Outputs decoded from the current state only.
  always_comb begin
    cfg_ready = (state_q == LOAD);
    cfg_done  = (state_q == ACTIVE);
    cfg_out   = cfg_out_q;
    lut_out   = (state_q == ACTIVE) ? lut_sel : '0;
  end

endmodule
